// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the parametrised synchronous FIFO
package sync_fifo_pkg;
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DATA_W x DEPTH dual-port RAM; ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read)
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]       rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with level, almost flags and sticky errors; ports: clk, rst_n, wr/data_in, rd/data_out, empty, full, almost_full, almost_empty, fifo_cnt, overflow, underflow
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    rd,
  output logic [DATA_W-1:0]       data_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ptr_w(DEPTH):0]   fifo_cnt,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] rdata;
  // A full FIFO still takes a write when a read frees a slot in the same cycle
  assign wr_acc = wr && (!full || rd);
  assign rd_acc = rd && !empty;
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = (wr_acc && !rd_acc) ? cnt_q + CW'(1) :
               (rd_acc && !wr_acc) ? cnt_q - CW'(1) : cnt_q;
    ovf_d    = ovf_q || (wr && full && !rd);
    unf_d    = unf_q || (rd && empty);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = rdata;
  end else begin : g_std
    // Read port sees the pre-edge word, so a simultaneous write to the freed slot cannot corrupt it
    logic [DATA_W-1:0] dout_q, dout_d;
    assign dout_d = rd_acc ? rdata : dout_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dout_q <= '0;
      else dout_q <= dout_d;
    assign data_out = dout_q;
  end
  assign fifo_cnt     = cnt_q;
  assign empty        = cnt_q == '0;
  assign full         = cnt_q == CW'(DEPTH);
  assign almost_full  = cnt_q >= CW'(AF_LEVEL);
  assign almost_empty = cnt_q <= CW'(AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: checks a registered-read FIFO against a queue model and a FWFT FIFO against a vector table
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0, dout0, dout1;
  logic       empty0, full0, af0, ae0, ovf0, unf0;
  logic       empty1, full1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  int         checks = 0, errors = 0;
  bit [7:0]   q[$];
  bit [7:0]   mdout;
  bit         movf, munf;
  typedef struct {
    bit       wr;
    bit       rd;
    bit [7:0] din;
    bit [7:0] dout;
    bit [2:0] cnt;
    bit [5:0] flg;
  } vec_t;
  vec_t tv[14];

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr(wr0), .data_in(din0), .rd(rd0), .data_out(dout0),
    .empty(empty0), .full(full0), .almost_full(af0), .almost_empty(ae0),
    .fifo_cnt(cnt0), .overflow(ovf0), .underflow(unf0)
  );
  sync_fifo_param #(.DATA_W(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr(wr1), .data_in(din1), .rd(rd1), .data_out(dout1),
    .empty(empty1), .full(full1), .almost_full(af1), .almost_empty(ae1),
    .fifo_cnt(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check0();
    int n = q.size();
    chk("cnt", 32'(cnt0), 32'(n));
    chk("empty", 32'(empty0), 32'(n == 0));
    chk("full", 32'(full0), 32'(n == 16));
    chk("almost_full", 32'(af0), 32'(n >= 14));
    chk("almost_empty", 32'(ae0), 32'(n <= 2));
    chk("overflow", 32'(ovf0), 32'(movf));
    chk("underflow", 32'(unf0), 32'(munf));
    chk("dout", 32'(dout0), 32'(mdout));
  endtask

  task automatic step0(input bit w, input bit r, input bit [7:0] d);
    int  n;
    bit  racc, wacc;
    wr0 = w; rd0 = r; din0 = d;
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b0;
    n    = q.size();
    racc = r && n > 0;
    wacc = w && (n < 16 || r);
    if (w && n == 16 && !r) movf = 1'b1;
    if (r && n == 0) munf = 1'b1;
    if (racc) mdout = q.pop_front();
    if (wacc) q.push_back(d);
    check0();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("async_rst_cnt", 32'(cnt0), 32'd0);
    chk("async_rst_empty", 32'(empty0), 32'd1);
    chk("async_rst_cnt1", 32'(cnt1), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    mdout = '0; movf = 1'b0; munf = 1'b0;
    check0();
    chk("rst_flags1", 32'({ae1, af1, empty1, full1, ovf1, unf1}), 32'b101000);
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 8'h11, 8'h11, 3'd1, 6'b100000};
    tv[1]  = '{1'b1, 1'b0, 8'h22, 8'h11, 3'd2, 6'b100000};
    tv[2]  = '{1'b0, 1'b1, 8'h00, 8'h22, 3'd1, 6'b100000};
    tv[3]  = '{1'b1, 1'b0, 8'h33, 8'h22, 3'd2, 6'b100000};
    tv[4]  = '{1'b1, 1'b0, 8'h44, 8'h22, 3'd3, 6'b010000};
    tv[5]  = '{1'b1, 1'b0, 8'h55, 8'h22, 3'd4, 6'b010100};
    tv[6]  = '{1'b1, 1'b0, 8'h66, 8'h22, 3'd4, 6'b010110};
    tv[7]  = '{1'b1, 1'b1, 8'h77, 8'h33, 3'd4, 6'b010110};
    tv[8]  = '{1'b0, 1'b1, 8'h00, 8'h44, 3'd3, 6'b010010};
    tv[9]  = '{1'b0, 1'b1, 8'h00, 8'h55, 3'd2, 6'b100010};
    tv[10] = '{1'b0, 1'b1, 8'h00, 8'h77, 3'd1, 6'b100010};
    tv[11] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 6'b101010};
    tv[12] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 6'b101011};
    tv[13] = '{1'b1, 1'b1, 8'h88, 8'h88, 3'd1, 6'b100011};
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) step0(1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 16; i++) step0(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 16; i++) step0(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step0(1'b1, 1'b0, 8'(i));
    step0(1'b1, 1'b0, 8'hEE);
    step0(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step0(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step0(1'b1, 1'b0, 8'h90 + 8'(i));
    do_reset();
    for (int i = 0; i < 16; i++) step0(1'b1, 1'b0, 8'h20 + 8'(i));
    for (int i = 0; i < 20; i++) step0(1'b1, 1'b1, 8'h40 + 8'(i));
    for (int i = 0; i < 16; i++) step0(1'b0, 1'b1, 8'h00);
    do_reset();
    step0(1'b1, 1'b1, 8'hA5);
    step0(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 600; i++) begin
      int ph = (i / 60) % 2;
      step0($urandom_range(0, 3) < (ph ? 3 : 1), $urandom_range(0, 3) < (ph ? 1 : 3), 8'($urandom));
    end
    do_reset();
    for (int i = 0; i < 14; i++) begin
      wr1 = tv[i].wr; rd1 = tv[i].rd; din1 = tv[i].din;
      @(posedge clk); #1;
      wr1 = 1'b0; rd1 = 1'b0;
      chk($sformatf("fwft_cnt[%0d]", i), 32'(cnt1), 32'(tv[i].cnt));
      chk($sformatf("fwft_flags[%0d]", i), 32'({ae1, af1, empty1, full1, ovf1, unf1}), 32'(tv[i].flg));
      if (tv[i].cnt != 3'd0) chk($sformatf("fwft_dout[%0d]", i), 32'(dout1), 32'(tv[i].dout));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: configurable data width, power-of-two depth, and read mode (registered or first-word-fall-through). It adds programmable almost-full/almost-empty flags, a level output, and sticky overflow/underflow error flags. It is the general-purpose buffer between producer and consumer blocks sharing one clock domain.

## Interface
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=4
- FWFT, 0, 0 = registered read (data one cycle after rd), 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, almost_full asserted when level >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr  in  1  write request
- data_in  in  DATA_W  write data
- rd  in  1  read request
- data_out  out  DATA_W  read data
- empty  out  1  no entries stored
- full  out  1  DEPTH entries stored
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- fifo_cnt  out  $clog2(DEPTH)+1  current level, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full and not accepted
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Write accepted (wr_acc) = wr && (!full || rd). Read accepted (rd_acc) = rd && !empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Each advances by 1 on its accept.
- Level update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither. The level never leaves 0..DEPTH.
- Full with wr && rd: both are accepted, level stays DEPTH, and the new word lands in the slot just freed.
- Empty with wr && rd: only the write is accepted, underflow is set, and the level becomes 1.
- wr && full && !rd: write is dropped, overflow is set, and memory and pointers are unchanged.
- overflow and underflow clear only on reset.
- FWFT=0: on rd_acc, data_out is loaded from mem[rd_ptr] at the clock edge. Otherwise data_out holds its value.
- FWFT=1: data_out = mem[rd_ptr] combinationally. It is valid whenever !empty and undefined-but-stable when empty. rd_acc pops the head.
- empty, full, almost_full and almost_empty are decoded combinationally from fifo_cnt.

## Timing
- Reset (asynchronous assert, synchronous release): pointers 0, fifo_cnt 0, empty 1, full 0, almost_empty 1, almost_full 0 (given AF_LEVEL>0), overflow 0, underflow 0. In FWFT=0 mode data_out is 0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Write-to-empty-deassert latency: 1 cycle (empty falls after the write edge).
- FWFT=0 read latency: 1 cycle from the rd_acc edge to data_out.
- FWFT=1: a word written at edge N is visible on data_out after edge N.
- Flags and fifo_cnt change only on clock edges (apart from reset) and are glitch-free relative to clk.
- Throughput: one write and one read per cycle sustained.

## Structure
- Package sync_fifo_pkg:
  - constant function for pointer width (clog2)
  - FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1)
- Sub-module fifo_mem:
  - DATA_W x DEPTH simple dual-port RAM: synchronous write, asynchronous read port
  - the top level adds the output register for FWFT=0
- Elaboration checks: DEPTH is a power of two; AE_LEVEL < AF_LEVEL <= DEPTH.

## Test plan
- Reset then idle: all outputs hold reset values. Assert rst_n low between edges → fifo_cnt 0 and empty 1 without a clock edge.
- DATA_W=8, DEPTH=16, FWFT=0: write 0x00..0x0F → full=1, fifo_cnt=16, almost_full from level 14. Then read 16 → data_out 0x00..0x0F, each one cycle after its rd, then empty=1.
- Full + 17th write with rd=0 → overflow=1 sticky, fifo_cnt 16, the next reads return 0x00..0x0F (data unchanged). Then reset → overflow=0.
- Full with wr=rd=1 for 20 cycles, pointers wrapping → fifo_cnt stays 16, read order matches write order, no overflow.
- Empty with wr=rd=1, data_in=0xA5 → underflow=1, fifo_cnt=1. A following read returns 0xA5.
- FWFT=1, DEPTH=4: write 0x11 → data_out=0x11 after the same edge with rd low. Write 0x22, then rd → data_out=0x22 next cycle. almost_empty tracks level <= 2 throughout.
